// File: rtl/sht40_pkg.sv
// Shared constants and FSM encoding for the SHT40 frame decoder.
package sht40_pkg;

  localparam logic [7:0] CRC_POLY = 8'h31;
  localparam logic [7:0] CRC_INIT = 8'hFF;

  localparam int T_SCALE     = 17500;
  localparam int RH_SCALE    = 12500;
  localparam int T_OFFSET    = 4500;
  localparam int RH_OFFSET   = 600;
  localparam int RH_MAX      = 10000;
  localparam int FRAME_BYTES = 6;

  typedef enum logic [2:0] {
    WAIT_BYTE,
    CRC_SHIFT,
    CHECK_T,
    CHECK_RH,
    MULT,
    SCALE
  } state_e;

endpackage

// File: rtl/sht40_crc8_serial.sv
// Serial CRC-8 (poly 0x31, MSB first), one bit per clock after a byte load.
module sht40_crc8_serial
  import sht40_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init_i,
  input  logic       load_i,
  input  logic [7:0] data_i,
  output logic       done_o,
  output logic [7:0] residue_o
);

  logic [7:0] crc_q, sh_q;
  logic [3:0] cnt_q;
  logic       fb;

  assign fb = crc_q[7] ^ sh_q[7];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= CRC_INIT;
      sh_q  <= 8'h00;
      cnt_q <= 4'd0;
    end else if (init_i) begin
      // init also cancels any shift in flight (frame discard)
      crc_q <= CRC_INIT;
      cnt_q <= 4'd0;
    end else if (load_i) begin
      sh_q  <= data_i;
      cnt_q <= 4'd8;
    end else if (cnt_q != 4'd0) begin
      crc_q <= {crc_q[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
      sh_q  <= {sh_q[6:0], 1'b0};
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // High during the cycle whose closing edge performs the final shift.
  assign done_o    = (cnt_q == 4'd1);
  assign residue_o = crc_q;

endmodule

// File: rtl/sht40_frame_decoder.sv
// Decodes a 6-byte SHT40 measurement frame: CRC check per word, then scale to centi-units.
module sht40_frame_decoder
  import sht40_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [15:0] temp_raw,
  output logic [15:0] rh_raw,
  output logic [15:0] temp_centi,
  output logic [13:0] rh_centi,
  output logic        crc_err_t,
  output logic        crc_err_rh,
  output logic        data_valid,
  output logic        frame_abort
);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        accept, crc_init, crc_done;
  logic [7:0]  crc_res;
  logic [15:0] t_word_q, rh_word_q;
  logic        err_t_q, err_rh_q;
  logic [30:0] prod_t_q, prod_rh_q;
  logic [14:0] rh_int;
  logic [15:0] temp_next;
  logic [13:0] rh_next;

  sht40_crc8_serial u_crc (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_i    (crc_init),
    .load_i    (accept),
    .data_i    (byte_in),
    .done_o    (crc_done),
    .residue_o (crc_res)
  );

  assign byte_ready = (state_q == WAIT_BYTE);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept   = 1'b0;
    crc_init = 1'b0;
    if (frame_start) begin
      state_d  = WAIT_BYTE;
      cnt_d    = 3'd0;
      crc_init = 1'b1;
    end else begin
      case (state_q)
        WAIT_BYTE: if (byte_valid) begin
          accept  = 1'b1;
          cnt_d   = cnt_q + 3'd1;
          state_d = CRC_SHIFT;
        end
        // cnt_q already counts the byte being shifted
        CRC_SHIFT: if (crc_done) begin
          if (cnt_q == 3'(FRAME_BYTES / 2))  state_d = CHECK_T;
          else if (cnt_q == 3'(FRAME_BYTES)) state_d = CHECK_RH;
          else                               state_d = WAIT_BYTE;
        end
        CHECK_T: begin
          crc_init = 1'b1;
          state_d  = WAIT_BYTE;
        end
        CHECK_RH: begin
          crc_init = 1'b1;
          state_d  = MULT;
        end
        MULT:  state_d = SCALE;
        SCALE: begin
          state_d = WAIT_BYTE;
          cnt_d   = 3'd0;
        end
        default: state_d = WAIT_BYTE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_BYTE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Scaling: integer part of product/65536, minus offset; RH clamped to 0..RH_MAX.
  always_comb begin
    temp_next = {1'b0, prod_t_q[30:16]} - 16'(T_OFFSET);
    rh_int    = prod_rh_q[30:16];
    if (rh_int < 15'(RH_OFFSET))               rh_next = 14'd0;
    else if (rh_int > 15'(RH_OFFSET + RH_MAX)) rh_next = 14'(RH_MAX);
    else                                       rh_next = 14'(rh_int - 15'(RH_OFFSET));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_word_q    <= 16'h0;
      rh_word_q   <= 16'h0;
      err_t_q     <= 1'b0;
      err_rh_q    <= 1'b0;
      prod_t_q    <= 31'h0;
      prod_rh_q   <= 31'h0;
      temp_raw    <= 16'h0;
      rh_raw      <= 16'h0;
      temp_centi  <= 16'h0;
      rh_centi    <= 14'h0;
      crc_err_t   <= 1'b0;
      crc_err_rh  <= 1'b0;
      data_valid  <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      data_valid  <= 1'b0;
      frame_abort <= frame_start && (cnt_q != 3'd0) && (cnt_q <= 3'(FRAME_BYTES - 1));
      if (accept) begin
        case (cnt_q)
          3'd0: t_word_q[15:8]  <= byte_in;
          3'd1: t_word_q[7:0]   <= byte_in;
          3'd3: rh_word_q[15:8] <= byte_in;
          3'd4: rh_word_q[7:0]  <= byte_in;
          default: ;
        endcase
      end
      if (!frame_start) begin
        if (state_q == CHECK_T)  err_t_q  <= (crc_res != 8'h00);
        if (state_q == CHECK_RH) err_rh_q <= (crc_res != 8'h00);
        if (state_q == MULT) begin
          prod_t_q  <= 31'(t_word_q) * 31'(T_SCALE);
          prod_rh_q <= 31'(rh_word_q) * 31'(RH_SCALE);
        end
        if (state_q == SCALE) begin
          temp_raw   <= t_word_q;
          rh_raw     <= rh_word_q;
          temp_centi <= temp_next;
          rh_centi   <= rh_next;
          crc_err_t  <= err_t_q;
          crc_err_rh <= err_rh_q;
          data_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sht40_frame_decoder.sv
// Scoreboard bench: frames driven with random spacing, results checked against an arithmetic model.
module tb_sht40_frame_decoder;

  logic        clk = 1'b0, rst_n = 1'b1, frame_start = 1'b0, byte_valid = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_ready, crc_err_t, crc_err_rh, data_valid, frame_abort;
  logic [15:0] temp_raw, rh_raw, temp_centi;
  logic [13:0] rh_centi;

  sht40_frame_decoder dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .temp_raw(temp_raw),
    .rh_raw(rh_raw), .temp_centi(temp_centi), .rh_centi(rh_centi),
    .crc_err_t(crc_err_t), .crc_err_rh(crc_err_rh), .data_valid(data_valid),
    .frame_abort(frame_abort)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] traw, rhraw;
    int          tc, rc;
    bit          et, erh;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  int cyc = 0, n_chk = 0, n_pass = 0, last_acc = 0, bytes_in_frame = 0;
  int exp_aborts = 0, n_aborts = 0, n_pushed = 0, n_dv = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic logic [7:0] crc8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0]  c;
    logic [15:0] w;
    c = 8'hFF;
    w = {a, b};
    for (int i = 15; i >= 0; i--) begin
      if (c[7] ^ w[i]) c = (c << 1) ^ 8'h31;
      else             c = c << 1;
    end
    return c;
  endfunction

  // Monitor: every data_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_abort) n_aborts++;
      if (data_valid) begin
        n_dv++;
        if (sbq.size() == 0) begin
          chk("unexpected_data_valid", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("latency_cycle", cyc, e.cyc);
          chk("temp_raw", temp_raw, e.traw);
          chk("rh_raw", rh_raw, e.rhraw);
          chk("temp_centi", $signed(temp_centi), e.tc);
          chk("rh_centi", rh_centi, e.rc);
          chk("crc_err_t", crc_err_t, e.et);
          chk("crc_err_rh", crc_err_rh, e.erh);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge with byte_valid still high.
  task automatic send_byte(input logic [7:0] b, output int waits);
    waits = 0;
    byte_in = b;
    byte_valid = 1'b1;
    while (!byte_ready && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 100) chk("byte_ready_timeout", 0, 1);
    @(negedge clk);
    last_acc = cyc;
    bytes_in_frame++;
  endtask

  task automatic idle(input int n);
    byte_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [15:0] t, input logic [15:0] rh,
                            input logic [7:0] tx, input logic [7:0] rx, input bit hold);
    logic [7:0] b[6];
    int gaps[6] = '{0, 8, 8, 9, 8, 8};
    int w;
    exp_t e;
    b[0] = t[15:8];  b[1] = t[7:0];  b[2] = crc8(t[15:8], t[7:0]) ^ tx;
    b[3] = rh[15:8]; b[4] = rh[7:0]; b[5] = crc8(rh[15:8], rh[7:0]) ^ rx;
    for (int i = 0; i < 6; i++) begin
      send_byte(b[i], w);
      if (hold && i > 0) chk("ready_gap", w, gaps[i]);
      if (!hold) idle($urandom_range(0, 3));
    end
    byte_valid = 1'b0;
    e.traw  = t;
    e.rhraw = rh;
    e.tc    = (int'(t) * 17500) / 65536 - 4500;
    e.rc    = (int'(rh) * 12500) / 65536 - 600;
    if (e.rc < 0)     e.rc = 0;
    if (e.rc > 10000) e.rc = 10000;
    e.et    = (tx != 8'h00);
    e.erh   = (rx != 8'h00);
    e.cyc   = last_acc + 11;
    sbq.push_back(e);
    n_pushed++;
    bytes_in_frame = 0;
    idle(4);
  endtask

  task automatic pulse_start(input bit with_byte);
    frame_start = 1'b1;
    byte_valid  = with_byte;
    byte_in     = 8'h55;
    @(negedge clk);
    frame_start = 1'b0;
    byte_valid  = 1'b0;
    if (bytes_in_frame >= 1 && bytes_in_frame <= 5) exp_aborts++;
    bytes_in_frame = 0;
    @(negedge clk);
  endtask

  initial begin
    int w;
    #1 rst_n = 1'b0;
    #10;
    chk("rst_byte_ready", byte_ready, 1);
    chk("rst_data_valid", data_valid, 0);
    chk("rst_temp_centi", temp_centi, 0);
    chk("rst_rh_raw", rh_raw, 0);
    chk("rst_crc_err", {crc_err_t, crc_err_rh}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start(1'b0);

    send_frame(16'h6666, 16'h8000, 8'h00, 8'h00, 1'b0);
    send_frame(16'hBEEF, 16'hBEEF, 8'h00, 8'h01, 1'b1);
    send_frame(16'h0000, 16'h0000, 8'h00, 8'h00, 1'b0);
    send_frame(16'hFFFF, 16'hFFFF, 8'h40, 8'h00, 1'b1);

    // Partial frame discarded; start pulse coincides with a valid byte that must be ignored.
    send_byte(8'h12, w); send_byte(8'h34, w); send_byte(8'h56, w);
    idle(12);
    pulse_start(1'b1);
    send_frame(16'h7A3C, 16'h4E21, 8'h00, 8'h00, 1'b0);
    idle(20);
    chk("no_extra_dv_after_abort", sbq.size(), 0);
    chk("abort_pulses", n_aborts, exp_aborts);

    // Asynchronous reset in the middle of byte 4's CRC shift.
    send_byte(8'h11, w); send_byte(8'h22, w); send_byte(crc8(8'h11, 8'h22), w);
    send_byte(8'h33, w); send_byte(8'h44, w);
    byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_byte_ready", byte_ready, 1);
    chk("async_rst_temp_raw", temp_raw, 0);
    chk("async_rst_rh_centi", rh_centi, 0);
    chk("async_rst_temp_centi", temp_centi, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bytes_in_frame = 0;
    @(negedge clk);
    send_frame(16'h5A5A, 16'h1234, 8'h00, 8'h00, 1'b0);

    for (int k = 0; k < 14; k++) begin
      logic [7:0] tx, rx;
      tx = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      rx = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      send_frame(16'($urandom), 16'($urandom), tx, rx, 1'($urandom_range(0, 1)));
    end

    for (int k = 0; k < 200 && sbq.size() != 0; k++) @(negedge clk);
    idle(5);
    chk("scoreboard_drained", sbq.size(), 0);
    chk("data_valid_count", n_dv, n_pushed);
    chk("abort_total", n_aborts, exp_aborts);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
